branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised, registered branch resolver for the execute stage. Compares rs1/rs2
//  internally, evaluates conditional-branch funct3 and computes target and next PC.
//  Flags mispredicts against the front-end prediction and holds one result in an
//  output register with valid/ready handshake. Sits between operand read and PC-select/flush logic.
// PARAMETERS
//  XLEN    32  operand, PC and immediate width
//  STAT_W  16  width of statistics counters (BRU_STATS_EN only)
//  ILEN_B  4   byte increment for fall-through PC (pc_i + ILEN_B)
// PORTS
//  clk_i           in   1     clock, rising edge
//  rst_i           in   1     reset, asynchronous, active-high
//  valid_i         in   1     input beat valid
//  ready_o         out  1     unit can accept a beat
//  funct3_i        in   3     branch op: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
//  rs1_i, rs2_i    in   XLEN  operands
//  pc_i            in   XLEN  branch instruction PC
//  imm_i           in   XLEN  sign-extended B-immediate
//  pred_taken_i    in   1     front-end prediction
//  flush_i         in   1     kill in-flight and presented beats
//  valid_o         out  1     result valid
//  ready_i         in   1     consumer accepts result
//  taken_o         out  1     condition true
//  target_o        out  XLEN  pc_i + imm_i
//  next_pc_o       out  XLEN  taken ? target : pc_i + ILEN_B
//  mispredict_o    out  1     taken_o != pred_taken_i
//  illegal_o       out  1     funct3 is 010 or 011
// BEHAVIOUR
//  - Reset: valid_o=0; taken_o, mispredict_o, illegal_o=0; target_o, next_pc_o=0.
//  - ready_o = ~valid_o | ready_i (combinational). Accept = valid_i & ready_o & ~flush_i.
//  - Latency 1: an accepted beat appears on outputs next cycle with valid_o=1.
//  - Output register holds stable while valid_o & ~ready_i; no input accepted then.
//  - Back-to-back: valid_o & ready_i & accept -> register reloads, valid_o stays 1.
//  - valid_o & ready_i & no accept -> valid_o=0 next cycle.
//  - flush_i has top priority: valid_o=0 next cycle; beat presented that cycle is dropped.
//  - Conditions: eq = rs1==rs2; lt signed; ltu unsigned. BGE = ~lt, BGEU = ~ltu
//    (equality included). Illegal funct3: taken=0, illegal_o=1, next_pc = fall-through.
//  - Address arithmetic is modulo 2^XLEN; carry out is discarded (wrap, no fault).
//  - mispredict_o computed on the registered taken, so illegal + pred_taken=1 -> mispredict=1.
//  - Reset mid-operation clears the held result immediately (asynchronous reset).
// CONFIGURATION
//  BRU_STATS_EN defined: adds outputs stat_branches_o[STAT_W] and stat_mispred_o[STAT_W].
//    Both reset to 0 and count on the output handshake (valid_o & ready_i).
//    stat_mispred_o counts handshakes with mispredict_o=1. Both saturate at all-ones.
//    Flushed beats are not counted.
//  Not defined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package branch_pkg: funct3 localparams (BEQ..BGEU) and a branch_op_e typedef;
//    shared with the decoder.
//  Sub-module branch_cmp: combinational eq/lt/ltu over XLEN plus funct3 -> taken/illegal.
//  Top holds the handshake, output register, address adders and optional counters.
// TESTING
//  1 BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> next cycle taken=1,
//    next_pc=0x120, mispredict=1.
//  2 BGE rs1=rs2=-3; BGEU rs1=1, rs2=0xFFFFFFFF -> taken=1, then taken=0.
//    BLT rs1=-1, rs2=1 -> taken=1.
//  3 Hold ready_i=0 for 3 cycles with valid_o=1 -> outputs stable, ready_o=0,
//    new beat not accepted. Then 4 back-to-back beats with ready_i=1 -> 4 results, no bubbles.
//  4 flush_i with valid_o=1 and valid_i=1 -> valid_o=0 next cycle, both beats lost.
//    Raise rst_i mid-stall -> valid_o=0 at once.
//  5 funct3=010, pred=1 -> illegal=1, taken=0, mispredict=1.
//    pc=0xFFFFFFFC, imm=8, BEQ taken -> next_pc=0x4 (wrap).
//  6 BRU_STATS_EN, STAT_W=2: 5 handshakes, 2 mispredicts, 1 flushed beat
//    -> stat_branches_o=3 (saturated), stat_mispred_o=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Branch op encodings shared between the decoder and the branch resolve unit.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Every funct3 value has a member so a cast from the raw field is always legal.
    typedef enum logic [2:0] {
        BR_BEQ  = F3_BEQ,
        BR_BNE  = F3_BNE,
        BR_RSV2 = 3'b010,
        BR_RSV3 = 3'b011,
        BR_BLT  = F3_BLT,
        BR_BGE  = F3_BGE,
        BR_BLTU = F3_BLTU,
        BR_BGEU = F3_BGEU
    } branch_op_e;

    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Handshake/operand bundle for branch_resolve_unit.
// BRU_STATS_EN adds the statistics counter outputs.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAT_W = 16
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic            pred_taken_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic            taken_o;
    logic [XLEN-1:0] target_o;
    logic [XLEN-1:0] next_pc_o;
    logic            mispredict_o;
    logic            illegal_o;
`ifdef BRU_STATS_EN
    logic [STAT_W-1:0] stat_branches_o;
    logic [STAT_W-1:0] stat_mispred_o;
`endif

    if (STAT_W == 0) begin : g_stat_w_chk
        $error("STAT_W must be nonzero");
    end

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i, pred_taken_i,
               flush_i, ready_i,
        input  ready_o, valid_o, taken_o, target_o, next_pc_o, mispredict_o,
               illegal_o
`ifdef BRU_STATS_EN
        , input stat_branches_o, stat_mispred_o
`endif
    );

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i, pred_taken_i,
               flush_i, ready_i,
        output ready_o, valid_o, taken_o, target_o, next_pc_o, mispredict_o,
               illegal_o
`ifdef BRU_STATS_EN
        , output stat_branches_o, stat_mispred_o
`endif
    );

endinterface

// File: rtl/branch_cmp.sv
// Combinational operand compare and funct3 condition evaluation.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    // Select the branch condition; reserved encodings never take.
    always_comb begin
        taken   = 1'b0;
        illegal = is_illegal_f3(funct3);
        case (branch_op_e'(funct3))
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = ~eq;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = ~lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: compare, target/next-PC, mispredict flag,
// single-entry output register with valid/ready handshake.
// BRU_STATS_EN adds saturating branch and mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAT_W = 16,
    parameter int unsigned ILEN_B = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    branch_resolve_unit_if.slave  bus
);

    logic            cmp_taken;
    logic            cmp_illegal;
    logic [XLEN-1:0] target_d;
    logic [XLEN-1:0] fall_d;
    logic            accept;

    logic            valid_q;
    logic            taken_q;
    logic            illegal_q;
    logic            pred_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] next_pc_q;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1     (bus.rs1_i),
        .rs2     (bus.rs2_i),
        .funct3  (bus.funct3_i),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    if (STAT_W == 0) begin : g_stat_w_chk
        $error("STAT_W must be nonzero");
    end

    // Address adders wrap modulo 2^XLEN.
    assign target_d = bus.pc_i + bus.imm_i;
    assign fall_d   = bus.pc_i + XLEN'(ILEN_B);

    assign bus.ready_o = ~valid_q | bus.ready_i;
    assign accept      = bus.valid_i & bus.ready_o & ~bus.flush_i;

    // Output register: flush wins, then load on accept, then drain on consume.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            pred_q    <= 1'b0;
            target_q  <= '0;
            next_pc_q <= '0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            taken_q   <= cmp_taken;
            illegal_q <= cmp_illegal;
            pred_q    <= bus.pred_taken_i;
            target_q  <= target_d;
            next_pc_q <= cmp_taken ? target_d : fall_d;
        end else if (bus.ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.valid_o      = valid_q;
    assign bus.taken_o      = taken_q;
    assign bus.illegal_o    = illegal_q;
    assign bus.target_o     = target_q;
    assign bus.next_pc_o    = next_pc_q;
    // Mispredict derives from the registered outcome, so reset leaves it low.
    assign bus.mispredict_o = taken_q ^ pred_q;

`ifdef BRU_STATS_EN
    logic [STAT_W-1:0] stat_br_q;
    logic [STAT_W-1:0] stat_mp_q;
    logic              handshake;

    assign handshake = valid_q & bus.ready_i & ~bus.flush_i;

    // Saturating counters advanced on each consumed result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (handshake) begin
            if (stat_br_q != '1) begin
                stat_br_q <= stat_br_q + 1'b1;
            end
            if (bus.mispredict_o && (stat_mp_q != '1)) begin
                stat_mp_q <= stat_mp_q + 1'b1;
            end
        end
    end

    assign bus.stat_branches_o = stat_br_q;
    assign bus.stat_mispred_o  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (BRU_STATS_EN optional).
module tb_branch_resolve_unit;

`ifdef BRU_STATS_EN
    localparam int unsigned SW = 2;
`else
    localparam int unsigned SW = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32), .STAT_W(SW)) bus ();

    branch_resolve_unit #(.XLEN(32), .STAT_W(SW), .ILEN_B(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        taken;
        logic        illegal;
        logic        pred;
        logic [31:0] target;
        logic [31:0] next_pc;
    } res_t;

    logic        m_valid = 1'b0;
    res_t        m_res   = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    int unsigned m_br    = 0;
    int unsigned m_mp    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch semantics straight from the ISA definition.
    function automatic res_t resolve(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] pc,
                                     input logic [31:0] imm, input logic pred);
        res_t r;
        int sa = a;
        int sb = b;
        longint unsigned sum = longint'(pc) + longint'(imm);
        r.taken   = 1'b0;
        r.illegal = 1'b0;
        case (f3)
            3'd0: r.taken = (a == b);
            3'd1: r.taken = (a != b);
            3'd4: r.taken = (sa < sb);
            3'd5: r.taken = (sa >= sb);
            3'd6: r.taken = (a < b);
            3'd7: r.taken = (a >= b);
            default: r.illegal = 1'b1;
        endcase
        r.pred    = pred;
        r.target  = sum[31:0];
        r.next_pc = r.taken ? r.target : pc + 32'd4;
        return r;
    endfunction

    // Reference model: one-entry result buffer following the handshake rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_res   = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
            m_br    = 0;
            m_mp    = 0;
        end else begin
            if (m_valid && bus.ready_i && !bus.flush_i) begin
                if (m_br < (1 << SW) - 1) m_br++;
                if ((m_res.taken != m_res.pred) && (m_mp < (1 << SW) - 1)) m_mp++;
            end
            if (bus.flush_i) begin
                m_valid = 1'b0;
            end else if (bus.valid_i && (!m_valid || bus.ready_i)) begin
                m_valid = 1'b1;
                m_res   = resolve(bus.funct3_i, bus.rs1_i, bus.rs2_i, bus.pc_i,
                                  bus.imm_i, bus.pred_taken_i);
            end else if (bus.ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_o", 64'(bus.valid_o), 64'(m_valid));
            chk("ready_o", 64'(bus.ready_o), 64'(!m_valid || bus.ready_i));
            if (m_valid) begin
                chk("taken_o", 64'(bus.taken_o), 64'(m_res.taken));
                chk("illegal_o", 64'(bus.illegal_o), 64'(m_res.illegal));
                chk("target_o", 64'(bus.target_o), 64'(m_res.target));
                chk("next_pc_o", 64'(bus.next_pc_o), 64'(m_res.next_pc));
                chk("mispredict_o", 64'(bus.mispredict_o), 64'(m_res.taken != m_res.pred));
            end
`ifdef BRU_STATS_EN
            chk("stat_branches_o", 64'(bus.stat_branches_o), 64'(m_br));
            chk("stat_mispred_o", 64'(bus.stat_mispred_o), 64'(m_mp));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        bus.valid_i      = 1'b1;
        bus.funct3_i     = f3;
        bus.rs1_i        = a;
        bus.rs2_i        = b;
        bus.pc_i         = pc;
        bus.imm_i        = imm;
        bus.pred_taken_i = pred;
    endtask

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        present(f3, a, b, pc, imm, pred);
        step();
        bus.valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_t;
        bus.valid_i      = 1'b0;
        bus.funct3_i     = 3'd0;
        bus.rs1_i        = '0;
        bus.rs2_i        = '0;
        bus.pc_i         = '0;
        bus.imm_i        = '0;
        bus.pred_taken_i = 1'b0;
        bus.flush_i      = 1'b0;
        bus.ready_i      = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_taken", 64'(bus.taken_o), 64'd0);
        chk("rst_mispredict", 64'(bus.mispredict_o), 64'd0);
        chk("rst_illegal", 64'(bus.illegal_o), 64'd0);
        chk("rst_target", 64'(bus.target_o), 64'd0);
        chk("rst_next_pc", 64'(bus.next_pc_o), 64'd0);
        rst = 1'b0;
        step();

        // BEQ taken, predicted not taken
        send(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        chk("t1_valid", 64'(bus.valid_o), 64'd1);
        chk("t1_taken", 64'(bus.taken_o), 64'd1);
        chk("t1_next_pc", 64'(bus.next_pc_o), 64'h120);
        chk("t1_mispredict", 64'(bus.mispredict_o), 64'd1);

        // BGE equal, BGEU 1 vs max, BLT -1 vs 1
        send(3'b101, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h200, 32'h10, 1'b1);
        chk("t2_bge_eq", 64'(bus.taken_o), 64'd1);
        send(3'b111, 32'd1, 32'hFFFF_FFFF, 32'h200, 32'h10, 1'b0);
        chk("t2_bgeu", 64'(bus.taken_o), 64'd0);
        chk("t2_bgeu_next_pc", 64'(bus.next_pc_o), 64'h204);
        send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
        chk("t2_blt", 64'(bus.taken_o), 64'd1);
        step();
        chk("t2_drain", 64'(bus.valid_o), 64'd0);

        // Stall three cycles, then four back-to-back beats
        bus.ready_i = 1'b0;
        send(3'b001, 32'd1, 32'd2, 32'h300, 32'h40, 1'b0);
        held_t = bus.target_o;
        chk("t3_held_target", 64'(held_t), 64'h340);
        present(3'b000, 32'd9, 32'd9, 32'h400, 32'h4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_stall_ready", 64'(bus.ready_o), 64'd0);
            chk("t3_stall_valid", 64'(bus.valid_o), 64'd1);
            chk("t3_stall_target", 64'(bus.target_o), 64'h340);
        end
        bus.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(3'b000, 32'd9, 32'd9, 32'h400 + 32'(i) * 32'h100, 32'h4, 1'b1);
            step();
            chk("t3_b2b_valid", 64'(bus.valid_o), 64'd1);
            chk("t3_b2b_target", 64'(bus.target_o), 64'h404 + 64'(i) * 64'h100);
        end
        bus.valid_i = 1'b0;
        step();

        // Flush with a held result and a presented beat
        bus.ready_i = 1'b0;
        send(3'b000, 32'd1, 32'd1, 32'h800, 32'h8, 1'b0);
        chk("t4_held", 64'(bus.valid_o), 64'd1);
        present(3'b001, 32'd1, 32'd2, 32'h900, 32'h8, 1'b0);
        bus.flush_i = 1'b1;
        bus.ready_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("t4_flush_valid", 64'(bus.valid_o), 64'd0);
        step();
        chk("t4_beat_lost", 64'(bus.valid_o), 64'd0);

        // Asynchronous reset while stalled
        bus.ready_i = 1'b0;
        send(3'b000, 32'd3, 32'd3, 32'hA00, 32'h8, 1'b0);
        chk("t4_stall_valid", 64'(bus.valid_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", 64'(bus.valid_o), 64'd0);
        chk("t4_rst_target", 64'(bus.target_o), 64'd0);
        step();
        rst = 1'b0;
        bus.ready_i = 1'b1;
        step();

        // Illegal funct3 and PC wrap
        send(3'b010, 32'd7, 32'd7, 32'h900, 32'h10, 1'b1);
        chk("t5_illegal", 64'(bus.illegal_o), 64'd1);
        chk("t5_ill_taken", 64'(bus.taken_o), 64'd0);
        chk("t5_ill_mispredict", 64'(bus.mispredict_o), 64'd1);
        chk("t5_ill_next_pc", 64'(bus.next_pc_o), 64'h904);
        send(3'b000, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h8, 1'b1);
        chk("t5_wrap_next_pc", 64'(bus.next_pc_o), 64'h4);
        chk("t5_wrap_mispredict", 64'(bus.mispredict_o), 64'd0);
        step();

`ifdef BRU_STATS_EN
        // Five handshakes (two mispredicts) then one flushed beat
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_br", 64'(bus.stat_branches_o), 64'd0);
        send(3'b000, 32'd1, 32'd1, 32'h10, 32'h4, 1'b0);
        send(3'b000, 32'd1, 32'd1, 32'h10, 32'h4, 1'b1);
        send(3'b000, 32'd1, 32'd1, 32'h10, 32'h4, 1'b1);
        send(3'b000, 32'd1, 32'd1, 32'h10, 32'h4, 1'b0);
        send(3'b000, 32'd1, 32'd1, 32'h10, 32'h4, 1'b1);
        step();
        bus.ready_i = 1'b0;
        send(3'b000, 32'd1, 32'd1, 32'h10, 32'h4, 1'b0);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        step();
        chk("t6_stat_branches", 64'(bus.stat_branches_o), 64'd3);
        chk("t6_stat_mispred", 64'(bus.stat_mispred_o), 64'd2);
        bus.ready_i = 1'b1;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
